// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI event parser.
//   - status nibble and system byte constants
//   - midi_event_t: one decoded note event (19 bits)
//   - parser_state_t: byte-level parser state
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  typedef struct packed {
    logic       note_on;
    logic [3:0] channel;
    logic [6:0] key;
    logic [6:0] velocity;
  } midi_event_t;

  typedef enum logic [1:0] {
    ST_NO_STATUS = 2'd0,
    ST_DATA1     = 2'd1,
    ST_DATA2     = 2'd2,
    ST_SYSEX     = 2'd3
  } parser_state_t;

endpackage

// File: rtl/midi_event_fifo.sv
// First-word fall-through FIFO of midi_event_t with sticky overflow.
// Ports:
//   clk, rst (async active-low)
//   push, push_data       write side; a push while full without a pop is dropped
//   pop_ready             consumer takes the head when pop_valid=1
//   pop_valid, pop_data   head entry (pop_data reads 0 when empty)
//   clear_overflow        clears overflow; a simultaneous drop wins
//   overflow              sticky drop flag
//   count                 occupied entries
module midi_event_fifo
  import midi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  midi_event_t              push_data,
  input  logic                     pop_ready,
  output logic                     pop_valid,
  output midi_event_t              pop_data,
  input  logic                     clear_overflow,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  midi_event_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, do_pop, do_push, drop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = !empty && pop_ready;
  // a pop frees the slot in the same cycle, so a push onto a full FIFO is kept
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign pop_valid = !empty;
  assign pop_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver.
// Ports:
//   clk, rst (async active-low)
//   rx     serial input, idle high
//   data   received byte, valid when valid=1
//   valid  one-cycle strobe per correctly framed byte
module uart_receive #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 31250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);

  localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W   = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 2;
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYC / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  rx_state_t        state;
  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_s;

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= 2'b11;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data    <= '0;
      valid   <= 1'b0;
    end else begin
      sync  <= {sync[0], rx};
      valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_LOAD;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            // a glitch shorter than half a bit is not a start bit
            if (!rx_s) begin
              cnt     <= BIT_LOAD;
              bit_idx <= '0;
              state   <= RX_BITS;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_BITS: begin
          if (cnt == '0) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= BIT_LOAD;
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (cnt == '0) begin
            if (rx_s) begin
              data  <= shreg;
              valid <= 1'b1;
            end
            state <= RX_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/midi_event_parser.sv
// MIDI byte parser: decodes Note On / Note Off on masked channels and queues
// them in an event FIFO with valid/ready output.
// Ports:
//   clk, rst (async active-low)
//   din             MIDI serial line
//   dout_ready      consumer accepts head event
//   clear_overflow  clears sticky overflow
//   dout_valid      head event valid
//   note_on, channel, key, velocity  head event fields
//   overflow        an event was dropped on a full FIFO
//   fifo_count      occupied FIFO entries
//
// state        | meaning
// ST_NO_STATUS | no running status, data bytes discarded
// ST_DATA1     | next data byte is d1
// ST_DATA2     | next data byte is d2, message completes
// ST_SYSEX     | inside SysEx, data bytes discarded
module midi_event_parser
  import midi_pkg::*;
#(
  parameter int          CLK_FREQ     = 50_000_000,
  parameter int          BAUD_RATE    = 31250,
  parameter logic [15:0] CHANNEL_MASK = 16'h0200,
  parameter int          FIFO_DEPTH   = 8,
  parameter bit          VEL0_IS_OFF  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din,
  input  logic                         dout_ready,
  input  logic                         clear_overflow,
  output logic                         dout_valid,
  output logic                         note_on,
  output logic [3:0]                   channel,
  output logic [6:0]                   key,
  output logic [6:0]                   velocity,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  logic [7:0]    rx_data;
  logic          byte_valid;
  parser_state_t state;
  logic [7:0]    status;
  logic [6:0]    d1;
  logic          push_valid;
  midi_event_t   push_event;
  midi_event_t   head;

  uart_receive #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_rx (
    .clk   (clk),
    .rst   (rst),
    .rx    (din),
    .data  (rx_data),
    .valid (byte_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_NO_STATUS;
      status     <= '0;
      d1         <= '0;
      push_valid <= 1'b0;
      push_event <= '0;
    end else begin
      push_valid <= 1'b0;
      // real-time bytes fall through untouched, even mid-message
      if (byte_valid && rx_data < RT_MIN) begin
        if (rx_data == SYSEX_START) begin
          state <= ST_SYSEX;
        end else if (rx_data == SYSEX_END) begin
          state <= ST_NO_STATUS;
        end else if (rx_data[7:4] == 4'hF) begin
          status <= '0;
          state  <= ST_NO_STATUS;
        end else if (rx_data[7]) begin
          status <= rx_data;
          state  <= ST_DATA1;
        end else begin
          case (state)
            ST_DATA1: begin
              d1 <= rx_data[6:0];
              // one-data-byte messages complete here and stay in DATA1
              if (status[7:4] != PROG && status[7:4] != CHAN_AT)
                state <= ST_DATA2;
            end
            ST_DATA2: begin
              state <= ST_DATA1;
              if ((status[7:4] == NOTE_ON || status[7:4] == NOTE_OFF) &&
                  CHANNEL_MASK[status[3:0]]) begin
                push_valid          <= 1'b1;
                push_event.note_on  <= (status[7:4] == NOTE_ON) &&
                                       !(VEL0_IS_OFF && rx_data[6:0] == 7'd0);
                push_event.channel  <= status[3:0];
                push_event.key      <= d1;
                push_event.velocity <= rx_data[6:0];
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  midi_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .push           (push_valid),
    .push_data      (push_event),
    .pop_ready      (dout_ready),
    .pop_valid      (dout_valid),
    .pop_data       (head),
    .clear_overflow (clear_overflow),
    .overflow       (overflow),
    .count          (fifo_count)
  );

  assign note_on  = head.note_on;
  assign channel  = head.channel;
  assign key      = head.key;
  assign velocity = head.velocity;

endmodule

// File: doc/midi_event_parser.md
Name: midi_event_parser

Overview:
- Parametrised successor to the single-channel MIDI note-on decoder.
- Receives serial MIDI through uart_receive at 31250 baud and decodes Note On and Note Off on any channel selected by a mask.
- Supports running status, real-time interleaving and SysEx skipping.
- Buffers decoded events in a FIFO with a valid/ready output, so the drum voice allocator can apply backpressure.

Parameters:
- BAUD_RATE, 31250: passed to uart_receive.
- CHANNEL_MASK, 16'h0200: bit n set accepts MIDI channel n (0-based). Default is channel 10 only.
- FIFO_DEPTH, 8: event FIFO entries. Power of 2, at least 2.
- VEL0_IS_OFF, 1: when 1, Note On with velocity 0 is reported as a note-off.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- din  input  1  MIDI serial line.
- dout_ready  input  1  consumer accepts the head event.
- clear_overflow  input  1  clears the overflow flag.
- dout_valid  output  1  head event valid.
- note_on  output  1  1 = note-on, 0 = note-off.
- channel  output  4  MIDI channel, 0-based.
- key  output  7  note number.
- velocity  output  7  velocity (release velocity for 0x8n).
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries.

Behaviour:
- Reset: asserting rst (low) asynchronously clears all of the following.
  - Parser state returns to NO_STATUS.
  - FIFO is emptied.
  - dout_valid=0, overflow=0, fifo_count=0.
  - note_on, channel, key and velocity read 0.
- Byte classes, per uart_receive strobe:
  - Real-time (0xF8-0xFF): ignored. State and running status are unchanged, including mid-message.
  - 0xF0: enter SYSEX.
  - 0xF7: return to NO_STATUS.
  - Other system common (0xF1-0xF6): clear running status and enter NO_STATUS. Their data bytes are discarded.
  - Channel status (0x80-0xEF): latch it as running status, clear the data index, and go to DATA1. The status also terminates SYSEX.
- Parser states:
  - NO_STATUS: data bytes are discarded.
  - DATA1: data byte is stored as d1.
    - For 0xCn/0xDn the message completes here; nothing is emitted, and the state stays DATA1 (running status).
    - Otherwise go to DATA2.
  - DATA2: data byte is stored as d2, the message completes, and the state returns to DATA1 (running status).
  - SYSEX: all data bytes are discarded.
- Emission: a message completes only in DATA2. It is emitted only if all of these hold:
  - the status is 0x8n or 0x9n;
  - CHANNEL_MASK[n]=1.
  0xAn, 0xBn and 0xEn are consumed silently.
- Event fields:
  - note_on = (status==0x9n) && !(VEL0_IS_OFF && d2==0).
  - key = d1[6:0], velocity = d2[6:0].
- Latency:
  - Byte strobe in cycle N: the event is registered in the push stage at the N→N+1 edge.
  - It is written to the FIFO at the N+1→N+2 edge, so dout_valid is high in N+2 if the FIFO was empty.
- FIFO:
  - First-word fall-through. Outputs show the head entry whenever dout_valid=1 and are held stable until popped.
  - Pop happens on a cycle with dout_valid && dout_ready.
  - Push while full with no pop in the same cycle: the event is dropped and overflow is set.
  - Push while full with a pop in the same cycle: accepted; count is unchanged.
  - Push and pop while empty: the push is accepted; dout_valid rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Cleared on a clear_overflow cycle.
  - If a drop coincides with clear_overflow, set wins.
- Reset mid-message discards any partial message. The first data byte after reset, with no status byte, is ignored.

Decomposition:
- midi_pkg holds:
  - status nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, POLY_AT=4'hA, CC=4'hB, PROG=4'hC, CHAN_AT=4'hD, PITCH=4'hE);
  - SYSEX_START=8'hF0, SYSEX_END=8'hF7, RT_MIN=8'hF8;
  - typedef midi_event_t, a packed struct {note_on, channel[3:0], key[6:0], velocity[6:0]} of 19 bits;
  - the parser state enum.
- Sub-module: midi_event_fifo, a generic FWFT FIFO of midi_event_t parameterised by depth.
- uart_receive is reused unchanged.

Test Plan:
- 0x99 0x24 0x64 with dout_ready=1 -> one event {note_on=1, channel=9, key=0x24, velocity=0x64}; dout_valid is high exactly 2 cycles after the last byte strobe.
- 0x99 0x26 0x50 0x26 0x00 (running status, VEL0_IS_OFF=1) -> two events: {1,9,0x26,0x50}, then {0,9,0x26,0x00}.
- 0x99 0x24 0xF8 0x64, then 0xF0 0x01 0x02 0xF7 0x89 0x24 0x40 -> {1,9,0x24,0x64}, then {0,9,0x24,0x40}; the clock byte and SysEx produce nothing.
- 0x90 0x30 0x7F (channel 0, masked off), then 0xB9 0x07 0x10 and 0xC9 0x05 0x99 0x31 0x20 -> only {1,9,0x31,0x20} is emitted.
- dout_ready=0 with FIFO_DEPTH=8 and 9 note-ons sent -> fifo_count=8 and overflow=1. Then dout_ready=1 -> the first 8 events drain in order and the 9th never appears. A clear_overflow pulse then gives overflow=0.
- Reset pulled low after 0x99 0x24, then released, then 0x64 sent -> no event. Outputs are 0 during reset.
